// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480 raster counters, blanking, strobes,
// delayed active-low hs/vs and a 16-bit completed-frame counter.
// Ports: vga_clk, Reset (sync, high) -> DrawX, DrawY, blank,
//        hs, vs, line_start, frame_start, frame_count.
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int SYNC_DELAY = 1
) (
    input  logic        vga_clk,
    input  logic        Reset,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_TOTAL < 1 || V_TOTAL < 1) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL/V_TOTAL must be 1..1024");
    end
    if (SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_bad_delay
        $error("vga_timing_gen: SYNC_DELAY must be 0..4");
    end

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    // Thresholds kept 11 bits wide so a value of 1024 does not alias to 0.
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_STOP  = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_STOP  = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic       h_wrap;
    logic       v_wrap;
    logic [9:0] hc_n;
    logic [9:0] vc_n;
    logic       hs_raw;
    logic       vs_raw;

    always_comb begin
        h_wrap = (DrawX == H_LAST);
        v_wrap = h_wrap && (DrawY == V_LAST);
        hc_n   = h_wrap ? 10'd0 : DrawX + 10'd1;
        if (v_wrap)
            vc_n = 10'd0;
        else if (h_wrap)
            vc_n = DrawY + 10'd1;
        else
            vc_n = DrawY;
        hs_raw = !(({1'b0, DrawX} >= HS_START) && ({1'b0, DrawX} < HS_STOP));
        vs_raw = !(({1'b0, DrawY} >= VS_START) && ({1'b0, DrawY} < VS_STOP));
    end

    // Strobes and blank decode the next-state counters so they land
    // in the same cycle as the DrawX/DrawY value they describe.
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            DrawX       <= 10'd0;
            DrawY       <= 10'd0;
            blank       <= 1'b1;
            line_start  <= 1'b1;
            frame_start <= 1'b1;
            frame_count <= 16'd0;
        end else begin
            DrawX       <= hc_n;
            DrawY       <= vc_n;
            blank       <= ({1'b0, hc_n} < H_VIS) && ({1'b0, vc_n} < V_VIS);
            line_start  <= (hc_n == 10'd0);
            frame_start <= (hc_n == 10'd0) && (vc_n == 10'd0);
            if (v_wrap)
                frame_count <= frame_count + 16'd1;
        end
    end

    // Sync delay matches the renderers' registered RGB; reset flushes
    // every stage to the idle level so no stale pulse survives.
    if (SYNC_DELAY == 0) begin : g_nodelay
        assign hs = hs_raw;
        assign vs = vs_raw;
    end else begin : g_delay
        logic [SYNC_DELAY-1:0] hs_pipe;
        logic [SYNC_DELAY-1:0] vs_pipe;

        always_ff @(posedge vga_clk) begin
            if (Reset) begin
                hs_pipe <= '1;
                vs_pipe <= '1;
            end else begin
                hs_pipe[0] <= hs_raw;
                vs_pipe[0] <= vs_raw;
                for (int i = 1; i < SYNC_DELAY; i++) begin
                    hs_pipe[i] <= hs_pipe[i-1];
                    vs_pipe[i] <= vs_pipe[i-1];
                end
            end
        end

        assign hs = hs_pipe[SYNC_DELAY-1];
        assign vs = vs_pipe[SYNC_DELAY-1];
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Pixel-timing source for the 640x480 display path. It generates the DrawX/DrawY/blank raster that every sprite renderer consumes (renderers address their ROM from DrawX/DrawY and gate RGB on blank), and the hs/vs sync pulses. The sync pulses are delayed so they line up with the renderers' registered RGB. It also issues per-line and per-frame strobes and a frame counter, which game logic uses for animation and countdown timing.

## Interface

Parameters:
- H_VISIBLE, 640: active pixels per line
- H_FRONT, 16: horizontal front porch, in pixels
- H_SYNC, 96: hsync width, in pixels
- H_BACK, 48: horizontal back porch, in pixels
- V_VISIBLE, 480: active lines per frame
- V_FRONT, 10: vertical front porch, in lines
- V_SYNC, 2: vsync width, in lines
- V_BACK, 33: vertical back porch, in lines
- SYNC_DELAY, 1: pipeline depth, in cycles, applied to hs/vs only; range 0..4

Ports:
- vga_clk, input, 1: pixel clock; all state changes on its rising edge
- Reset, input, 1: synchronous reset, active-high
- DrawX, output, 10: current horizontal count
- DrawY, output, 10: current vertical count
- blank, output, 1: 1 = pixel is visible (DrawX < H_VISIBLE and DrawY < V_VISIBLE); 0 = blanking
- hs, output, 1: horizontal sync, active-low, delayed by SYNC_DELAY
- vs, output, 1: vertical sync, active-low, delayed by SYNC_DELAY
- line_start, output, 1: one-cycle pulse while DrawX == 0
- frame_start, output, 1: one-cycle pulse while DrawX == 0 and DrawY == 0
- frame_count, output, 16: number of completed frames, modulo 2^16

## Operation

- Derived totals: H_TOTAL = sum of the four H_* parameters (800 by default); V_TOTAL = sum of the four V_* parameters (525 by default). Both totals must be ≤ 1024. An elaboration-time check flags a violation.
- Horizontal counter hc: 0 .. H_TOTAL-1. It increments every cycle and wraps from H_TOTAL-1 to 0.
- Vertical counter vc: 0 .. V_TOTAL-1. It increments only on an hc wrap, and wraps from V_TOTAL-1 to 0 on the cycle where hc also wraps.
- DrawX = hc and DrawY = vc. Both are registers; there is no combinational path from Reset.
- blank, line_start and frame_start are registered. They are decoded from the next-state counter values, so each one is aligned to the same cycle as the DrawX/DrawY value it describes.
- Raw hsync is low when H_VISIBLE+H_FRONT ≤ hc < H_VISIBLE+H_FRONT+H_SYNC. By default that is 656..751.
- Raw vsync is low when V_VISIBLE+V_FRONT ≤ vc < V_VISIBLE+V_FRONT+V_SYNC. By default that is 490..491, across whole lines.
- hs and vs are raw sync passed through a SYNC_DELAY-stage shift register. With SYNC_DELAY = 0, hs/vs are aligned with DrawX.
- frame_count increments in the same cycle that the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0, 0). It is therefore already incremented in the cycle where frame_start = 1. It wraps from 0xFFFF to 0x0000.

## Timing

- Values while Reset = 1 and in the first cycle after Reset falls:
  - DrawX = 0, DrawY = 0, blank = 1
  - line_start = 1, frame_start = 1
  - hs = 1, vs = 1, with all delay stages loaded with 1
  - frame_count = 0
- In the second cycle after Reset falls, DrawX = 1 and the strobes are 0.
- Reset asserted mid-frame: at the next edge the counters return to (0, 0) and frame_count returns to 0. The sync pipeline flushes to 1 immediately; no stale sync pulse emerges from it afterward.
- hs is low for exactly H_SYNC cycles per line.
- vs is low for exactly V_SYNC × H_TOTAL cycles per frame.
- Both sync edges lag their raw counter position by exactly SYNC_DELAY cycles.
- blank goes 1 → 0 on the cycle where DrawX becomes H_VISIBLE. It goes 0 → 1 on the cycle where DrawX becomes 0 and DrawY < V_VISIBLE.
- Frame period is H_TOTAL × V_TOTAL cycles, which is 420000 by default.

## Test plan

- Reset held 5 cycles, then released → during reset and in the first free cycle: DrawX = 0, DrawY = 0, blank = 1, frame_start = 1, hs = 1, vs = 1, frame_count = 0. In the next cycle DrawX = 1 and frame_start = 0.
- Run 1 line with defaults and SYNC_DELAY = 1:
  - blank falls when DrawX = 640.
  - hs falls one cycle after DrawX = 656 and rises one cycle after DrawX = 752, giving exactly 96 low cycles.
  - line_start fires again after 800 cycles with DrawY = 1.
- Run 1 full frame:
  - vs is low for 1600 consecutive cycles, starting SYNC_DELAY cycles after (DrawX, DrawY) = (0, 490).
  - blank stays 0 for all of DrawY = 480..524.
  - frame_start recurs after exactly 420000 cycles, with frame_count = 1 in that cycle.
- Reset asserted at (DrawX, DrawY) = (700, 300), inside hsync, for 1 cycle → the next cycle shows (0, 0) with hs = 1. The next hs low begins exactly SYNC_DELAY cycles after DrawX = 656.
- Reduced parameters (H: 4, 1, 1, 1; V: 2, 1, 1, 1; H_TOTAL = 7, V_TOTAL = 5), run 65537 frames → frame_count wraps 0xFFFF → 0x0000 on the 65536th frame_start and reads 0x0001 at the next. Also repeat the reset check with SYNC_DELAY = 0 and SYNC_DELAY = 4 and check the hs/vs alignment.
